i2s_stereo_transceiver: RTL and testbench

- Parametrised full-duplex stereo I2S master for the PMOD I2S2 codec path.
- Runs on one system clock, which is also forwarded as the codec MCLK. SCLK and LRCK are derived with clock-enable counters, not derived clocks.
- TX takes stereo pairs through a valid/ready handshake, buffers one pair and serialises both channels. Empty buffer at frame start flags underrun.
- RX deserialises both channels and emits one stereo pair per frame with a single-cycle valid pulse.

---
 rtl/i2s_stereo_transceiver.sv | 192 +++++++++++++++++++
 tb/tb_i2s_stereo_transceiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_stereo_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : i2s_stereo_transceiver
// Description : Full-duplex stereo I2S master. Forwards clk_in as MCLK and
//               derives SCLK/LRCK with clock-enable counters. TX buffers one
//               stereo pair behind a valid/ready handshake. RX emits one
//               stereo pair per frame with a one-cycle valid pulse.
//               Optional macro I2S_LEFT_JUSTIFIED_EN selects zero data offset
//               (left-justified) instead of the standard one-SCLK I2S offset.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_stereo_transceiver #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 24,
    parameter int SCLK_DIV     = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    tx_valid_in,
    output logic                    tx_ready_out,
    input  logic [SAMPLE_WIDTH-1:0] tx_left_in,
    input  logic [SAMPLE_WIDTH-1:0] tx_right_in,
    output logic                    tx_underrun_out,
    output logic                    rx_valid_out,
    output logic [SAMPLE_WIDTH-1:0] rx_left_out,
    output logic [SAMPLE_WIDTH-1:0] rx_right_out,
    output logic                    mclk_out,
    output logic                    sclk_out,
    output logic                    lrck_out,
    output logic                    sdout_out,
    input  logic                    sdin_in
);

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam int c_D = 0;
`else
    localparam int c_D = 1;
`endif

    localparam int c_FRAME = 2 * SLOT_WIDTH;
    localparam int c_PAD   = SLOT_WIDTH - SAMPLE_WIDTH;
    localparam int c_RXW   = SLOT_WIDTH + SAMPLE_WIDTH;
    localparam int c_DW    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int c_BW    = $clog2(c_FRAME);

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(SCLK_DIV - 1);
    localparam logic [c_DW-1:0] c_DIV_RISE = c_DW'(SCLK_DIV / 2 - 1);
    localparam logic [c_DW-1:0] c_DIV_HALF = c_DW'(SCLK_DIV / 2);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(c_FRAME - 1);
    localparam logic [c_BW-1:0] c_SLOT     = c_BW'(SLOT_WIDTH);
    // bit_cnt value at which the last right-channel sample bit is on the wire
    localparam logic [c_BW-1:0] c_RX_LAST  = c_BW'((c_RXW - 1 + c_D) % c_FRAME);

    // Timing counters and events
    logic [c_DW-1:0] r_div_cnt;
    logic [c_DW-1:0] w_div_nxt;
    logic [c_BW-1:0] r_bit_cnt;
    logic [c_BW-1:0] w_bit_nxt;
    logic            w_fall;
    logic            w_rise;
    logic            w_frame_start;
    logic            r_sclk;
    logic            r_lrck;

    // TX path
    logic                    r_tx_ready;
    logic                    r_underrun;
    logic                    r_sdout;
    logic [SAMPLE_WIDTH-1:0] r_hold_l;
    logic [SAMPLE_WIDTH-1:0] r_hold_r;
    logic [SLOT_WIDTH-1:0]   w_slot_l;
    logic [SLOT_WIDTH-1:0]   w_slot_r;
    logic [c_FRAME-1:0]      w_tx_load;
    logic [c_FRAME-1:0]      r_tx_sh;

    // RX path
    logic [c_RXW-2:0]        r_rx_sh;
    logic [c_RXW-1:0]        w_rx_nxt;
    logic                    r_rx_first;
    logic                    r_rx_valid;
    logic [SAMPLE_WIDTH-1:0] r_rx_l;
    logic [SAMPLE_WIDTH-1:0] r_rx_r;

    assign w_fall        = (r_div_cnt == c_DIV_LAST);
    assign w_rise        = (r_div_cnt == c_DIV_RISE);
    assign w_frame_start = w_fall && (r_bit_cnt == c_BIT_LAST);
    assign w_div_nxt     = w_fall ? '0 : r_div_cnt + c_DW'(1);
    assign w_bit_nxt     = !w_fall                    ? r_bit_cnt :
                           (r_bit_cnt == c_BIT_LAST)  ? '0        :
                                                        r_bit_cnt + c_BW'(1);

    // Samples are MSB-aligned in their slot with zero padding below.
    // An empty holding register at frame start sends a silent frame.
    assign w_slot_l  = SLOT_WIDTH'(r_hold_l) << c_PAD;
    assign w_slot_r  = SLOT_WIDTH'(r_hold_r) << c_PAD;
    assign w_tx_load = r_tx_ready ? '0 : {w_slot_l, w_slot_r};

    assign w_rx_nxt  = {r_rx_sh, sdin_in};

    // Divider and bit counter; SCLK/LRCK registered from the next counts
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_lrck    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_sclk    <= (w_div_nxt >= c_DIV_HALF);
            r_lrck    <= (w_bit_nxt >= c_SLOT);
        end
    end

    // TX handshake: one-pair holding register, drained at each frame start
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tx_ready <= 1'b1;
            r_underrun <= 1'b0;
            r_hold_l   <= '0;
            r_hold_r   <= '0;
        end else begin
            r_underrun <= w_frame_start && r_tx_ready;
            if (w_frame_start && !r_tx_ready) begin
                r_tx_ready <= 1'b1;
            end else if (tx_valid_in && r_tx_ready) begin
                r_hold_l   <= tx_left_in;
                r_hold_r   <= tx_right_in;
                r_tx_ready <= 1'b0;
            end
        end
    end

    // TX serialiser: sdout changes only on SCLK fall events
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tx_sh <= '0;
            r_sdout <= 1'b0;
        end else if (w_fall) begin
            if (w_frame_start) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
                r_sdout <= w_tx_load[c_FRAME-1];
                r_tx_sh <= w_tx_load << 1;
`else
                // Last bit of the previous frame goes out at bit_cnt 0
                r_sdout <= r_tx_sh[c_FRAME-1];
                r_tx_sh <= w_tx_load;
`endif
            end else begin
                r_sdout <= r_tx_sh[c_FRAME-1];
                r_tx_sh <= r_tx_sh << 1;
            end
        end
    end

    // RX deserialiser: sample on rise events, publish after last right bit
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rx_sh    <= '0;
            r_rx_first <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_l     <= '0;
            r_rx_r     <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_rise) begin
                r_rx_sh <= w_rx_nxt[c_RXW-2:0];
                if (r_bit_cnt == c_RX_LAST) begin
                    if (r_rx_first) begin
                        r_rx_first <= 1'b0;
                    end else begin
                        r_rx_valid <= 1'b1;
                        r_rx_l     <= w_rx_nxt[c_RXW-1 -: SAMPLE_WIDTH];
                        r_rx_r     <= w_rx_nxt[SAMPLE_WIDTH-1:0];
                    end
                end
            end
        end
    end

    assign mclk_out        = clk_in;
    assign sclk_out        = r_sclk;
    assign lrck_out        = r_lrck;
    assign sdout_out       = r_sdout;
    assign tx_ready_out    = r_tx_ready;
    assign tx_underrun_out = r_underrun;
    assign rx_valid_out    = r_rx_valid;
    assign rx_left_out     = r_rx_l;
    assign rx_right_out    = r_rx_r;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stereo_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_stereo_transceiver
// Description : Scoreboard bench for i2s_stereo_transceiver. A frame-level
//               reference model predicts bus waveforms, handshake state and
//               looped-back RX pairs from elapsed clock count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_stereo_transceiver;

    localparam int W   = 16;
    localparam int S   = 32;
    localparam int DIV = 4;
    localparam int FR  = 2 * S;
    localparam int FL  = FR * DIV;
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam int D = 0;
`else
    localparam int D = 1;
`endif

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_l     = '0;
    logic [W-1:0] tx_r     = '0;
    logic         tx_ready, tx_under, rx_valid, mclk, sclk, lrck, sdout, sdin;
    logic [W-1:0] rx_l, rx_r;
    logic         loop_en   = 1'b0;
    logic         pad_force = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rx   = 0;

    // Loopback; slot padding positions are forced high to prove RX ignores them
    assign sdin = loop_en & (pad_force | sdout);

    always #5 clk = ~clk;

    i2s_stereo_transceiver #(
        .SAMPLE_WIDTH (W),
        .SLOT_WIDTH   (S),
        .SCLK_DIV     (DIV)
    ) u_dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .tx_valid_in     (tx_valid),
        .tx_ready_out    (tx_ready),
        .tx_left_in      (tx_l),
        .tx_right_in     (tx_r),
        .tx_underrun_out (tx_under),
        .rx_valid_out    (rx_valid),
        .rx_left_out     (rx_l),
        .rx_right_out    (rx_r),
        .mclk_out        (mclk),
        .sclk_out        (sclk),
        .lrck_out        (lrck),
        .sdout_out       (sdout),
        .sdin_in         (sdin)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Stream bit at frame position p for a pair
    function automatic logic sbit(input logic [W-1:0] l, input logic [W-1:0] r, input int p);
        int idx;
        idx = p % S;
        if (idx >= W) return 1'b0;
        return (p >= S) ? r[W-1-idx] : l[W-1-idx];
    endfunction

    // ---------------- reference model (frame level) ----------------
    int           m_t;
    logic         m_ready;
    logic         m_under;
    logic [W-1:0] m_hl, m_hr, m_cl, m_cr, m_pl, m_pr;
    pair_t        exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_ready = 1'b1; m_under = 1'b0;
            m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0; m_pl = '0; m_pr = '0;
            exp_q.delete();
        end else begin
            m_t++;
            m_under = 1'b0;
            if (m_t % FL == 0) begin
                m_pl = m_cl;
                m_pr = m_cr;
                if (m_ready) begin
                    m_cl = '0; m_cr = '0; m_under = 1'b1;
                    if (tx_valid) begin
                        m_hl = tx_l; m_hr = tx_r; m_ready = 1'b0;
                    end
                end else begin
                    m_cl = m_hl; m_cr = m_hr; m_ready = 1'b1;
                end
                exp_q.push_back('{m_cl, m_cr});
            end else if (tx_valid && m_ready) begin
                m_hl = tx_l; m_hr = tx_r; m_ready = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int    mon_bc;
    logic  mon_eb;
    pair_t mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_bc = (m_t / DIV) % FR;
            chk("sclk", sclk, (m_t % DIV) >= DIV / 2);
            chk("lrck", lrck, mon_bc >= S);
            if (mon_bc >= D) mon_eb = sbit(m_cl, m_cr, mon_bc - D);
            else             mon_eb = sbit(m_pl, m_pr, FR - 1);
            chk("sdout", sdout, mon_eb);
            chk("tx_ready", tx_ready, m_ready);
            chk("tx_underrun", tx_under, m_under);
            chk("mclk", mclk, clk);
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rx_unexpected: got pair %0h/%0h expected none at %0t", rx_l, rx_r, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rx_left", rx_l, mon_e.l);
                    chk("rx_right", rx_r, mon_e.r);
                    n_rx++;
                end
            end
            pad_force = ((((mon_bc - D + FR) % FR) % S) >= W);
        end
    end

    // ---------------- stimulus ----------------
    task automatic reset_checks(input string tag);
        chk({tag, "_sclk"}, sclk, 0);
        chk({tag, "_lrck"}, lrck, 0);
        chk({tag, "_sdout"}, sdout, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_underrun"}, tx_under, 0);
        chk({tag, "_tx_ready"}, tx_ready, 1);
        chk({tag, "_rx_left"}, rx_l, 0);
        chk({tag, "_rx_right"}, rx_r, 0);
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        int k;
        k = 0;
        tx_valid = 1'b1;
        tx_l     = l;
        tx_r     = r;
        while (!tx_ready && k < 3 * FL) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) begin
            n_chk++;
            $display("FAIL tx_ready_timeout: got ready=0 expected 1 within %0d cycles", 3 * FL);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_nz();
        return W'($urandom_range(1, (1 << W) - 1));
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        #1 reset_checks("por");
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        loop_en = 1'b1;

        // Idle: silent frames with underrun each frame
        repeat (2 * FL) @(negedge clk);

        // Directed corner pattern, then randomized pairs with occasional gaps
        send(16'h8001, 16'h7FFE);
        for (int i = 0; i < 6; i++) begin
            send(rnd_nz(), rnd_nz());
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(FL / 2, 2 * FL)) @(negedge clk);
        end

        // Reset asserted mid right slot, between clock edges
        for (int k = 0; k < 2 * FL && (((m_t / DIV) % FR) != S + 5); k++) @(negedge clk);
        chk("reached_right_slot", ((m_t / DIV) % FR) == S + 5, 1);
        #2 rst_n = 1'b0;
        #1 reset_checks("mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream after clean restart
        for (int i = 0; i < 4; i++) send(rnd_nz(), rnd_nz());
        repeat (3 * FL) @(negedge clk);

        chk("rx_drain", exp_q.size() <= 1, 1);
        chk("rx_pairs_seen", n_rx >= 10, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
